ro_freq_counter: RTL

RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

---
 rtl/ro_pkg.sv | 24 ++
 rtl/ro_sync_edge.sv | 37 +++
 rtl/ro_freq_counter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ro_pkg.sv
// ---------------------------------------------------------------------------
// ro_pkg -- shared types and constants for the ring-oscillator frequency
// counter.
//   ro_state_t      : measurement FSM state encoding
//   RO_SYNC_STAGES  : depth of the osc_in metastability synchronizer
//   RO_AVG_WINDOWS  : number of gate windows averaged when RO_FREQ_AVG_EN
//                     is defined
//   RO_FLUSH_CYCLES : cycles spent letting the synchronizer settle after
//                     the oscillator is enabled
// ---------------------------------------------------------------------------
package ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } ro_state_t;

    localparam int RO_SYNC_STAGES  = 2;
    localparam int RO_AVG_WINDOWS  = 4;
    localparam int RO_FLUSH_CYCLES = 2;

endpackage

// File: rtl/ro_sync_edge.sv
// ---------------------------------------------------------------------------
// ro_sync_edge -- brings an asynchronous oscillator output into the clk
// domain through a flop synchronizer and emits a one-cycle pulse for every
// rising edge seen on the synchronized signal.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset, clears every flop
//   d    in  asynchronous input
//   rise out one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module ro_sync_edge
    import ro_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [RO_SYNC_STAGES-1:0] sync_q;
    logic                      last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage capture the
            // previous stage's old value, which is what forms a shift chain.
            sync_q <= {sync_q[RO_SYNC_STAGES-2:0], d};
            last_q <= sync_q[RO_SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[RO_SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/ro_freq_counter.sv
// ---------------------------------------------------------------------------
// ro_freq_counter -- measures a ring oscillator by counting its synchronized
// rising edges over a gate window of 2^GATE_LOG2 clk cycles.
// Sequence per start: IDLE -> FLUSH (2 cycles, oscillator on, nothing
// counted) -> COUNT (gate window) -> DONE (1 cycle, result valid) -> IDLE.
// Optional build macro RO_FREQ_AVG_EN: one start runs RO_AVG_WINDOWS
// back-to-back windows after a single FLUSH and reports their average.
// Parameters:
//   CNT_W     width of the edge counter and of count
//   GATE_LOG2 log2 of the gate window length in clk cycles (2..20)
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   osc_in   in  ring-oscillator output, asynchronous to clk
//   start    in  measurement request, honoured only in IDLE
//   osc_en   out ring enable, high in FLUSH and COUNT
//   busy     out high whenever the FSM is not IDLE
//   done     out one-cycle pulse, count/overflow are valid while it is high
//   count    out result of the last measurement, held until the next one
//   overflow out edge counter saturated during the last measurement
// ---------------------------------------------------------------------------
module ro_freq_counter
    import ro_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int GATE_LOG2 = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int                GATE_W     = GATE_LOG2 + 1;
    localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'((1 << GATE_LOG2) - 1);
    localparam logic [GATE_W-1:0] FLUSH_LAST = GATE_W'(RO_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    ro_state_t         state_q, state_d;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic              ovf_q, ovf_d;
    logic              edge_pulse;
    logic              flush_last, gate_last, last_window;
    logic [CNT_W-1:0]  result;
    logic              result_ovf;

    ro_sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (osc_in),
        .rise (edge_pulse)
    );

    // The gate counter also times FLUSH; it is cleared on every entry to
    // COUNT, including the hand-over between averaged windows.
    assign flush_last = (gate_q == FLUSH_LAST);
    assign gate_last  = (gate_q == GATE_LAST);

    // Saturating edge counter: an edge arriving at full scale is dropped and
    // remembered in the sticky overflow flag instead of wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        edge_d = edge_q;
        ovf_d  = ovf_q;
        if (edge_pulse) begin
            if (edge_q == CNT_MAX) ovf_d  = 1'b1;
            else                   edge_d = edge_q + CNT_W'(1);
        end
    end

`ifdef RO_FREQ_AVG_EN
    localparam int WIN_W = $clog2(RO_AVG_WINDOWS);
    localparam int ACC_W = CNT_W + WIN_W;

    logic [WIN_W-1:0] win_q;
    logic [ACC_W-1:0] acc_q, sum_d;
    logic             ovf_any_q;

    // edge_d already includes any edge in the window's final cycle.
    assign sum_d       = acc_q + ACC_W'(edge_d);
    assign last_window = (win_q == WIN_W'(RO_AVG_WINDOWS - 1));
    assign result      = sum_d[ACC_W-1:WIN_W];
    assign result_ovf  = ovf_any_q | ovf_d;

    always_ff @(posedge clk) begin
        if (rst || state_q == ST_FLUSH) begin
            win_q     <= '0;
            acc_q     <= '0;
            ovf_any_q <= 1'b0;
        end else if (state_q == ST_COUNT && gate_last) begin
            win_q     <= win_q + WIN_W'(1);
            acc_q     <= sum_d;
            ovf_any_q <= result_ovf;
        end
    end
`else
    assign last_window = 1'b1;
    assign result      = edge_d;
    assign result_ovf  = ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        osc_en  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                osc_en = 1'b1;
                if (flush_last) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                osc_en = 1'b1;
                if (gate_last && last_window) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The result is captured at the close of the last window, so it is
    // already on count while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gate_q   <= '0;
            edge_q   <= '0;
            ovf_q    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_FLUSH: begin
                    gate_q <= flush_last ? '0 : gate_q + GATE_W'(1);
                    edge_q <= '0;
                    ovf_q  <= 1'b0;
                end
                ST_COUNT: begin
                    if (gate_last) begin
                        gate_q <= '0;
                        edge_q <= '0;
                        ovf_q  <= 1'b0;
                        if (last_window) begin
                            count    <= result;
                            overflow <= result_ovf;
                        end
                    end else begin
                        gate_q <= gate_q + GATE_W'(1);
                        edge_q <= edge_d;
                        ovf_q  <= ovf_d;
                    end
                end
                default: begin
                    gate_q <= '0;
                    edge_q <= '0;
                    ovf_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
